// File: rtl/reg_scoreboard_file_if.sv
// Bundle of read, claim, writeback and status signals between the scheduler/writeback
// stages and the register scoreboard file.
interface reg_scoreboard_file_if #(
  parameter int NREGS  = 32,
  parameter int DATA_W = 64,
  parameter int NREAD  = 3,
  parameter int NWB    = 2
);
  localparam int IDX_W = $clog2(NREGS);

  logic [NREAD*IDX_W-1:0]  rd_idx;
  logic [NREAD*DATA_W-1:0] rd_data;
  logic [NREAD-1:0]        rd_busy;
  logic                    claim_valid;
  logic [IDX_W-1:0]        claim_idx;
  logic                    claim_ok;
  logic [NWB-1:0]          wb_valid;
  logic [NWB*IDX_W-1:0]    wb_idx;
  logic [NWB*DATA_W-1:0]   wb_data;
  logic [NWB-1:0]          wb_release;
  logic                    flush;
  logic                    any_busy;
  logic                    err_underflow;

  modport master (
    output rd_idx, claim_valid, claim_idx, wb_valid, wb_idx, wb_data, wb_release, flush,
    input  rd_data, rd_busy, claim_ok, any_busy, err_underflow
  );

  modport slave (
    input  rd_idx, claim_valid, claim_idx, wb_valid, wb_idx, wb_data, wb_release, flush,
    output rd_data, rd_busy, claim_ok, any_busy, err_underflow
  );
endinterface

// File: rtl/reg_scoreboard_file.sv
// Architectural register file with bypassed reads and per-register in-flight writer
// counters; claims reserve a destination, writeback releases it.
module reg_scoreboard_file #(
  parameter int NREGS   = 32,
  parameter int DATA_W  = 64,
  parameter int NREAD   = 3,
  parameter int NWB     = 2,
  parameter int CNT_W   = 2,
  parameter int RSP_IDX = 7,
  parameter logic [DATA_W-1:0] RSP_INIT = 'h7C00
) (
  input logic clk,
  input logic reset,
  reg_scoreboard_file_if.slave bus
);
  localparam int IDX_W = $clog2(NREGS);
  localparam int SUM_W = CNT_W + $clog2(NWB + 1) + 1;
  localparam logic [SUM_W-1:0] ONE     = SUM_W'(1);
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return int'(idx) < NREGS;
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [SUM_W-1:0] v);
    return (v > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : v[CNT_W-1:0];
  endfunction

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [CNT_W-1:0]  cnt_q  [NREGS];
  logic [CNT_W-1:0]  cnt_d  [NREGS];
  logic              err_q, err_d;

  logic [IDX_W-1:0]  wbi   [NWB];
  logic [DATA_W-1:0] wbd   [NWB];
  logic [IDX_W-1:0]  ridx  [NREAD];
  logic [DATA_W-1:0] rdata [NREAD];
  logic              rbusy [NREAD];
  logic [SUM_W-1:0]  rel_cnt [NREGS];
  logic              claim_ok;
  logic              any_busy;

  for (genvar k = 0; k < NWB; k++) begin : g_wb
    assign wbi[k] = bus.wb_idx[k*IDX_W +: IDX_W];
    assign wbd[k] = bus.wb_data[k*DATA_W +: DATA_W];
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    assign ridx[i] = bus.rd_idx[i*IDX_W +: IDX_W];
    assign bus.rd_data[i*DATA_W +: DATA_W] = rdata[i];
    assign bus.rd_busy[i] = rbusy[i];
  end

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      rel_cnt[r] = '0;
      for (int k = 0; k < NWB; k++)
        if (bus.wb_release[k] && int'(wbi[k]) == r) rel_cnt[r] = rel_cnt[r] + ONE;
    end
  end

  // A release in the same cycle frees a slot, so a saturated counter can still accept
  always_comb begin
    claim_ok = 1'b0;
    if (bus.claim_valid && !bus.flush && idx_ok(bus.claim_idx))
      claim_ok = (SUM_W'(cnt_q[bus.claim_idx]) + ONE) <= (CNT_MAX + rel_cnt[bus.claim_idx]);
  end

  always_comb begin
    logic [SUM_W-1:0] sum;
    sum   = '0;
    err_d = err_q;
    for (int r = 0; r < NREGS; r++) begin
      sum = SUM_W'(cnt_q[r]) + ((claim_ok && bus.claim_idx == IDX_W'(r)) ? ONE : '0);
      if (bus.flush) begin
        cnt_d[r] = '0;
      end else if (sum < rel_cnt[r]) begin
        cnt_d[r] = '0;
        err_d    = 1'b1;
      end else begin
        cnt_d[r] = sat_cnt(sum - rel_cnt[r]);
      end
    end
  end

  // Ascending port order lets the highest-numbered valid port win
  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < NWB; k++)
      if (bus.wb_valid[k] && idx_ok(wbi[k])) regs_d[wbi[k]] = wbd[k];
  end

  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      rdata[i] = '0;
      rbusy[i] = 1'b0;
      if (idx_ok(ridx[i])) begin
        rdata[i] = regs_q[ridx[i]];
        for (int k = 0; k < NWB; k++)
          if (bus.wb_valid[k] && wbi[k] == ridx[i]) rdata[i] = wbd[k];
        rbusy[i] = SUM_W'(cnt_q[ridx[i]]) > rel_cnt[ridx[i]];
      end
    end
  end

  always_comb begin
    any_busy = 1'b0;
    for (int r = 0; r < NREGS; r++) any_busy = any_busy | (cnt_q[r] != '0);
  end

  assign bus.claim_ok      = claim_ok;
  assign bus.any_busy      = any_busy;
  assign bus.err_underflow = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= (r == RSP_IDX) ? RSP_INIT : '0;
        cnt_q[r]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end
endmodule
